// File: rtl/dff_skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hbb_skid_pkg
// Description : Shared state encoding for the dff_skid_buffer pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package hbb_skid_pkg;

  // Occupancy of the stage: how many words it currently holds.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no word held
    BUSY  = 2'd1,  // main register holds a word
    FULL  = 2'd2   // main and skid registers both hold a word
  } skid_state_t;

endpackage : hbb_skid_pkg
`default_nettype wire

// File: rtl/dff_skid_buffer_dff_en.sv
`default_nettype none
// ============================================================================
// Module      : dff_en
// Description : WIDTH-bit register with synchronous clear and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_en #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Clear on reset, otherwise load only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : dff_en
`default_nettype wire

// File: rtl/dff_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dff_skid_buffer
// Description : Two-entry registered valid/ready stage. Data moves forward
//               through a main register; a skid register absorbs the one
//               extra word that arrives while in_ready is still high after
//               the consumer stalls. All handshake outputs come from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_skid_buffer
  import hbb_skid_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_o
);

  skid_state_t      state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             main_sel_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Transfers use only registered ready/valid, so no combinational
  // path exists from out_ready_i to in_ready_o or from in_valid_i onward.
  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Next-state and register enables from the current occupancy.
  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          // Consumer stalled while we were still ready: park the word.
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_fire) begin
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign main_d = main_sel_skid ? skid_q : in_i;

  // State plus registered handshake outputs, decoded from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  dff_en #(.WIDTH(WIDTH)) u_main (
    .clk  (clk),
    .rst  (rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  dff_en #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en),
    .d_i  (in_i),
    .q_o  (skid_q)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_o       = main_q;

endmodule : dff_skid_buffer
`default_nettype wire

// File: tb/tb_dff_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_skid_buffer
// Description : Directed and random self-checking bench for dff_skid_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_skid_buffer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_o;

  int n_checks;
  int n_fail;

  dff_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_i        (in_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_o       (out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic v, input logic [31:0] d, input logic r);
    check({tag, "_valid"}, {31'd0, out_valid_o}, {31'd0, v});
    check({tag, "_out"},   {24'd0, out_o},       d);
    check({tag, "_ready"}, {31'd0, in_ready_o},  {31'd0, r});
  endtask

  logic [WIDTH-1:0] sb[$];
  logic             prev_stall;
  logic [WIDTH-1:0] prev_out;
  logic             fire_in;
  logic             fire_out;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_i        = '0;
    out_ready_i = 1'b0;

    // ---------------- reset: 3 cycles held ----------------
    for (int i = 0; i < 3; i++) begin
      tick();
      expect3("rst_hold", 1'b0, 32'd0, 1'b0);
    end
    rst = 1'b0;
    tick();
    expect3("rst_release", 1'b0, 32'd0, 1'b1);

    // ---------------- pass-through 1,3,2 ----------------
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_i = 8'd1; tick(); expect3("pt0", 1'b1, 32'd1, 1'b1);
    in_i = 8'd3; tick(); expect3("pt1", 1'b1, 32'd3, 1'b1);
    in_i = 8'd2; tick(); expect3("pt2", 1'b1, 32'd2, 1'b1);
    in_valid_i = 1'b0;
    tick(); expect3("pt_idle", 1'b0, 32'd2, 1'b1);

    // ---------------- stall fill 1,2,3 ----------------
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_i = 8'd1; tick(); expect3("sf0", 1'b1, 32'd1, 1'b1);
    in_i = 8'd2; tick(); expect3("sf1", 1'b1, 32'd1, 1'b0);
    in_i = 8'd3; tick(); expect3("sf2", 1'b1, 32'd1, 1'b0);
    tick();              expect3("sf3", 1'b1, 32'd1, 1'b0);

    // ---------------- drain: 1 leaves, then 2, then 3 ----------------
    out_ready_i = 1'b1;
    tick(); expect3("dr0", 1'b1, 32'd2, 1'b1);
    tick(); expect3("dr1", 1'b1, 32'd3, 1'b1);
    in_valid_i = 1'b0;
    tick(); expect3("dr2", 1'b0, 32'd3, 1'b1);

    // ---------------- reset while FULL ----------------
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_i = 8'hA5; tick(); expect3("mr0", 1'b1, 32'hA5, 1'b1);
    in_i = 8'h5A; tick(); expect3("mr1", 1'b1, 32'hA5, 1'b0);
    rst = 1'b1;
    tick(); expect3("mr_rst", 1'b0, 32'd0, 1'b0);
    rst        = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick(); expect3("mr_after", 1'b0, 32'd0, 1'b1);
    tick(); expect3("mr_gone", 1'b0, 32'd0, 1'b1);

    // ---------------- random traffic vs scoreboard ----------------
    sb.delete();
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int c = 0; c < 1000; c++) begin
      check("rnd_valid", {31'd0, out_valid_o}, {31'd0, (sb.size() != 0)});
      check("rnd_ready", {31'd0, in_ready_o},  {31'd0, (sb.size() < 2)});
      if (sb.size() != 0) check("rnd_data", {24'd0, out_o}, {24'd0, sb[0]});
      if (prev_stall)     check("rnd_stable", {24'd0, out_o}, {24'd0, prev_out});
      check("rnd_inflight", sb.size(), (sb.size() <= 2) ? sb.size() : 32'd2);

      in_valid_i  = 1'($urandom_range(0, 1));
      out_ready_i = 1'($urandom_range(0, 1));
      in_i        = WIDTH'($urandom);
      fire_in  = in_valid_i & (sb.size() < 2);
      fire_out = out_ready_i & (sb.size() != 0);
      prev_stall = (sb.size() != 0) & ~out_ready_i;
      prev_out   = out_o;
      if (fire_out) void'(sb.pop_front());
      if (fire_in)  sb.push_back(in_i);
      tick();
    end

    // Drain remaining words and confirm nothing was lost or duplicated.
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("end_valid", {31'd0, out_valid_o}, {31'd0, (sb.size() != 0)});
      if (sb.size() != 0) begin
        check("end_data", {24'd0, out_o}, {24'd0, sb[0]});
        void'(sb.pop_front());
      end
      tick();
    end
    check("end_empty", {31'd0, out_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dff_skid_buffer
`default_nettype wire
